sha1_msg_ctrl: RTL and testbench

Multi-block message sequencer for the SHA-1 compression core (`sha1_core`). It accepts pre-padded 512-bit blocks through a valid/ready handshake and drives the core's start, data and chaining inputs. It seeds the first block with the SHA-1 initial vector and chains each block's result into the next. After the last block it presents the final 160-bit digest.

---
 rtl/sha1_msg_ctrl.sv | 155 +++++++++++++++
 tb/tb_sha1_msg_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_ctrl.sv
// Multi-block message sequencer for sha1_core: seeds the IV, chains results, presents the final digest.
// Optional block counter output o_blk_cnt is enabled by defining SHA1_MSG_CTRL_CNT_EN.
module sha1_msg_ctrl #(
   parameter logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0}
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [511:0] i_data,
   input  logic         i_first,
   input  logic         i_last,
   output logic [159:0] o_digest,
   output logic         o_digest_valid,
   output logic         o_busy,
   output logic         o_core_start,
   output logic [511:0] o_core_data,
   output logic [159:0] o_core_vin,
   input  logic [159:0] i_core_vout,
   input  logic         i_core_done
`ifdef SHA1_MSG_CTRL_CNT_EN
   ,
   output logic [15:0]  o_blk_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic [511:0]   r_core_data;
   logic [159:0]   r_core_vin;
   logic [159:0]   r_chain;
   logic [159:0]   r_digest;
   logic           r_digest_valid;
   logic           r_last;
   logic           r_done_q;

   logic           w_accept;
   logic           w_done_rise;
   logic           w_complete;
   logic           w_ready;
   logic           w_busy;
   logic           w_core_start;

   // Edge detection lets the core hold done high between blocks without a false completion.
   assign w_done_rise = i_core_done & ~r_done_q;
   assign w_accept    = i_valid & w_ready;
   assign w_complete  = (r_state == WAIT) & w_done_rise;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_busy       = 1'b1;
      w_core_start = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            w_busy  = 1'b0;
            if (i_valid) begin
               w_state_next = START;
            end
         end
         START: begin
            w_core_start = 1'b1;
            w_state_next = WAIT;
         end
         WAIT: begin
            if (w_done_rise) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_core_data    <= '0;
         r_core_vin     <= '0;
         r_chain        <= IV;
         r_digest       <= '0;
         r_digest_valid <= 1'b0;
         r_last         <= 1'b0;
         r_done_q       <= 1'b0;
      end else begin
         r_done_q       <= i_core_done;
         r_digest_valid <= 1'b0;
         if (w_accept) begin
            r_core_data <= i_data;
            r_last      <= i_last;
            r_core_vin  <= i_first ? IV : r_chain;
         end
         // The chain falls back to IV after a last block, so a stray non-first block starts fresh.
         if (w_complete) begin
            if (r_last) begin
               r_digest       <= i_core_vout;
               r_digest_valid <= 1'b1;
               r_chain        <= IV;
            end else begin
               r_chain        <= i_core_vout;
            end
         end
      end
   end

`ifdef SHA1_MSG_CTRL_CNT_EN
   logic        r_first;
   logic [15:0] r_blk_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_first   <= 1'b0;
         r_blk_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_first <= i_first;
         end
         if (w_complete) begin
            if (r_first) begin
               r_blk_cnt <= 16'd1;
            end else if (r_blk_cnt != 16'hFFFF) begin
               r_blk_cnt <= r_blk_cnt + 16'd1;
            end
         end
      end
   end

   assign o_blk_cnt = r_blk_cnt;
`endif

   assign o_ready        = w_ready;
   assign o_busy         = w_busy;
   assign o_core_start   = w_core_start;
   assign o_core_data    = r_core_data;
   assign o_core_vin     = r_core_vin;
   assign o_digest       = r_digest;
   assign o_digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha1_msg_ctrl.sv
// Directed bench for sha1_msg_ctrl with a behavioural SHA-1 core model (pulsed or level-held done).
// Define SHA1_MSG_CTRL_CNT_EN to also check o_blk_cnt.
module tb_sha1_msg_ctrl;

   localparam logic [159:0] IV       = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
   localparam logic [159:0] DIG_ABC  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] DIG_NUM  = 160'h50abf570_6a150990_a08b2c5e_a40fa0e5_85554732;
   localparam int           CORE_LAT = 5;
   localparam int           EXP_LAT  = CORE_LAT + 3;

   logic         clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_valid = 1'b0;
   logic [511:0] i_data = '0;
   logic         i_first = 1'b0;
   logic         i_last = 1'b0;
   logic         o_ready;
   logic [159:0] o_digest;
   logic         o_digest_valid;
   logic         o_busy;
   logic         o_core_start;
   logic [511:0] o_core_data;
   logic [159:0] o_core_vin;
   logic [159:0] i_core_vout;
   logic         i_core_done;
`ifdef SHA1_MSG_CTRL_CNT_EN
   logic [15:0]  o_blk_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sha1_msg_ctrl dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_data         (i_data),
      .i_first        (i_first),
      .i_last         (i_last),
      .o_digest       (o_digest),
      .o_digest_valid (o_digest_valid),
      .o_busy         (o_busy),
      .o_core_start   (o_core_start),
      .o_core_data    (o_core_data),
      .o_core_vin     (o_core_vin),
      .i_core_vout    (i_core_vout),
      .i_core_done    (i_core_done)
`ifdef SHA1_MSG_CTRL_CNT_EN
      ,
      .o_blk_cnt      (o_blk_cnt)
`endif
   );

   // Reference SHA-1 compression including the feed-forward add.
   function automatic logic [159:0] sha1_f(input logic [159:0] v, input logic [511:0] blk);
      logic [31:0] w [0:79];
      logic [31:0] a, b, c, d, e, f, k, t;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 80; i++) begin
         t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {t[30:0], t[31]};
      end
      a = v[159:128]; b = v[127:96]; c = v[95:64]; d = v[63:32]; e = v[31:0];
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
         else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
         t = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
      end
      return {v[159:128] + a, v[127:96] + b, v[95:64] + c, v[63:32] + d, v[31:0] + e};
   endfunction

   // Core model: fixed latency after start; done either pulses or stays high until the next start.
   logic         level_mode = 1'b0;
   logic         man_en = 1'b0;
   logic         man_done = 1'b0;
   logic [159:0] man_vout = '0;
   logic         model_done;
   logic [159:0] model_vout;
   logic [159:0] model_hold;
   int           model_cnt;

   always @(posedge clk) begin
      if (i_rst) begin
         model_done <= 1'b0;
         model_vout <= '0;
         model_cnt  <= 0;
      end else if (o_core_start) begin
         model_cnt  <= CORE_LAT;
         model_hold <= sha1_f(o_core_vin, o_core_data);
         if (level_mode) model_done <= 1'b0;
      end else if (model_cnt != 0) begin
         model_cnt <= model_cnt - 1;
         if (model_cnt == 1) begin
            model_done <= 1'b1;
            model_vout <= model_hold;
         end
      end else if (!level_mode) begin
         model_done <= 1'b0;
      end
   end

   assign i_core_done = man_en ? man_done : model_done;
   assign i_core_vout = man_en ? man_vout : model_vout;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sends one block and follows it to completion (o_ready back high).
   task automatic run_block(input logic [511:0] data, input logic first, input logic last,
                            input logic hold, input logic [511:0] nxt_data,
                            input logic nxt_first, input logic nxt_last,
                            output int lat, output int pulses,
                            output logic [159:0] vin_seen, output logic ok);
      int n;
      ok = 1'b1;
      pulses = 0;
      lat = 0;
      vin_seen = '0;
      i_data  = data;
      i_first = first;
      i_last  = last;
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 100) begin
         step();
         n++;
      end
      if (!o_ready) begin
         chk("accept_timeout", {511'd0, o_ready}, 512'd1);
         ok = 1'b0;
         i_valid = 1'b0;
         return;
      end
      @(posedge clk);
      step();
      chk("start_t1", {511'd0, o_core_start}, 512'd1);
      chk("ready_t1", {511'd0, o_ready}, 512'd0);
      if (hold) begin
         i_data  = nxt_data;
         i_first = nxt_first;
         i_last  = nxt_last;
      end else begin
         i_valid = 1'b0;
      end
      step();
      chk("start_width", {511'd0, o_core_start}, 512'd0);
      chk("core_data", o_core_data, data);
      vin_seen = o_core_vin;
      lat = 2;
      while (!o_ready && lat < 200) begin
         step();
         lat++;
         if (o_digest_valid) pulses++;
      end
      if (!o_ready) begin
         chk("done_timeout", {511'd0, o_ready}, 512'd1);
         ok = 1'b0;
      end
      if (hold) chk("data_held_until_idle", o_core_data, data);
      $display("block first=%0d last=%0d lat=%0d pulses=%0d vin=%h digest=%h",
               first, last, lat, pulses, vin_seen, o_digest);
   endtask

   typedef struct {
      logic [511:0] data;
      logic         first;
      logic         last;
      logic [159:0] vin;
      int           pulses;
      logic [159:0] digest;
      logic [15:0]  cnt;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [511:0] abc, b1, b2;
      logic [159:0] h1, vin_seen, xv;
      int lat, pulses, n;
      logic ok;

      abc = {32'h61626380, 416'h0, 32'h0, 32'h18};
      b1 = '0;
      b2 = '0;
      for (int k = 0; k < 64; k++) b1[511-8*k -: 8] = 8'((k + 1) % 10 + 48);
      for (int j = 0; j < 16; j++) b2[511-8*j -: 8] = 8'((65 + j) % 10 + 48);
      b2[511-8*16 -: 8] = 8'h80;
      b2[63:0] = 64'h280;
      h1 = sha1_f(IV, b1);

      vecs[0] = '{abc, 1'b1, 1'b1, IV, 1, DIG_ABC, 16'd1};
      vecs[1] = '{b1,  1'b1, 1'b0, IV, 0, DIG_ABC, 16'd1};
      vecs[2] = '{b2,  1'b0, 1'b1, h1, 1, DIG_NUM, 16'd2};
      vecs[3] = '{abc, 1'b1, 1'b1, IV, 1, DIG_ABC, 16'd1};
      vecs[4] = '{abc, 1'b0, 1'b1, IV, 1, DIG_ABC, 16'd2};

      repeat (50) step();
      chk("rst_ready", {511'd0, o_ready}, 512'd1);
      chk("rst_busy", {511'd0, o_busy}, 512'd0);
      chk("rst_start", {511'd0, o_core_start}, 512'd0);
      chk("rst_core_data", o_core_data, 512'd0);
      chk("rst_core_vin", {352'd0, o_core_vin}, 512'd0);
      chk("rst_digest", {352'd0, o_digest}, 512'd0);
      chk("rst_dvalid", {511'd0, o_digest_valid}, 512'd0);
`ifdef SHA1_MSG_CTRL_CNT_EN
      chk("rst_blk_cnt", {496'd0, o_blk_cnt}, 512'd0);
`endif
      i_rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
         run_block(vecs[i].data, vecs[i].first, vecs[i].last, 1'b0, '0, 1'b0, 1'b0,
                   lat, pulses, vin_seen, ok);
         if (ok) begin
            chk($sformatf("v%0d_vin", i), {352'd0, vin_seen}, {352'd0, vecs[i].vin});
            chk($sformatf("v%0d_pulses", i), 512'(pulses), 512'(vecs[i].pulses));
            chk($sformatf("v%0d_digest", i), {352'd0, o_digest}, {352'd0, vecs[i].digest});
            chk($sformatf("v%0d_latency", i), 512'(lat), 512'(EXP_LAT));
`ifdef SHA1_MSG_CTRL_CNT_EN
            chk($sformatf("v%0d_blk_cnt", i), {496'd0, o_blk_cnt}, {496'd0, vecs[i].cnt});
`endif
         end
         step();
         chk($sformatf("v%0d_dvalid_one_cycle", i), {511'd0, o_digest_valid}, 512'd0);
      end

      // i_valid held high across both blocks of the numeric message.
      run_block(b1, 1'b1, 1'b0, 1'b1, b2, 1'b0, 1'b1, lat, pulses, vin_seen, ok);
      chk("cont_b1_latency", 512'(lat), 512'(EXP_LAT));
      chk("cont_b1_pulses", 512'(pulses), 512'd0);
      run_block(b2, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, lat, pulses, vin_seen, ok);
      chk("cont_b2_vin", {352'd0, vin_seen}, {352'd0, h1});
      chk("cont_b2_latency", 512'(lat), 512'(EXP_LAT));
      chk("cont_b2_digest", {352'd0, o_digest}, {352'd0, DIG_NUM});
      chk("cont_b2_pulses", 512'(pulses), 512'd1);

      // Reset during WAIT of block 1; the aborted message must leave no trace.
      i_data = b1; i_first = 1'b1; i_last = 1'b0; i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 50) begin step(); n++; end
      @(posedge clk);
      step();
      i_valid = 1'b0;
      step();
      chk("abort_in_wait", {511'd0, o_busy}, 512'd1);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      chk("abort_ready", {511'd0, o_ready}, 512'd1);
      chk("abort_start", {511'd0, o_core_start}, 512'd0);
      chk("abort_core_vin", {352'd0, o_core_vin}, 512'd0);
      chk("abort_digest", {352'd0, o_digest}, 512'd0);
      pulses = 0;
      repeat (15) begin step(); if (o_digest_valid) pulses++; end
      chk("abort_no_pulse", 512'(pulses), 512'd0);
      run_block(abc, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, lat, pulses, vin_seen, ok);
      chk("after_abort_vin", {352'd0, vin_seen}, {352'd0, IV});
      chk("after_abort_digest", {352'd0, o_digest}, {352'd0, DIG_ABC});
      chk("after_abort_pulses", 512'(pulses), 512'd1);

      // Level-held done: still high while the next block sits in START.
      level_mode = 1'b1;
      for (int r = 0; r < 2; r++) begin
         run_block(abc, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, lat, pulses, vin_seen, ok);
         chk($sformatf("level%0d_latency", r), 512'(lat), 512'(EXP_LAT));
         chk($sformatf("level%0d_pulses", r), 512'(pulses), 512'd1);
         chk($sformatf("level%0d_digest", r), {352'd0, o_digest}, {352'd0, DIG_ABC});
         chk($sformatf("level%0d_done_high", r), {511'd0, i_core_done}, 512'd1);
      end
      level_mode = 1'b0;
      repeat (3) step();

      // Done rising edge inside START must be ignored; only the later edge completes.
      man_en = 1'b1;
      man_done = 1'b0;
      xv = 160'h0123456789abcdef_fedcba9876543210_a5a5a5a5;
      i_data = abc; i_first = 1'b1; i_last = 1'b1; i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 50) begin step(); n++; end
      @(posedge clk);
      step();
      i_valid = 1'b0;
      man_done = 1'b1;
      step();
      chk("start_edge_ignored_t2", {511'd0, o_busy}, 512'd1);
      step();
      chk("start_edge_ignored_t3", {511'd0, o_busy}, 512'd1);
      chk("start_edge_no_pulse", {511'd0, o_digest_valid}, 512'd0);
      man_done = 1'b0;
      step();
      step();
      chk("manual_before_edge", {511'd0, o_ready}, 512'd0);
      man_vout = xv;
      man_done = 1'b1;
      step();
      chk("manual_dvalid", {511'd0, o_digest_valid}, 512'd1);
      chk("manual_digest", {352'd0, o_digest}, {352'd0, xv});
      chk("manual_ready", {511'd0, o_ready}, 512'd1);
      $display("manual done sequence digest=%h", o_digest);
      man_en = 1'b0;
      man_done = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
